// File: rtl/rc4_ksa_engine_pkg.sv
// Shared types and default geometry for the RC4 S-box init / key-scheduling engine.
// The state helper keeps the busy decode in one place for the engine and its users.
package rc4_pkg;

  localparam int RC4_ADDR_W    = 8;
  localparam int RC4_DATA_W    = 8;
  localparam int RC4_KEY_BYTES = 3;

  typedef enum logic [3:0] {
    IDLE,
    INIT_WR,
    RD_I,
    WAIT_I,
    CAP_I,
    RD_J,
    WAIT_J,
    CAP_J,
    WR_I,
    WR_J,
    DONE
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Control and S-box RAM port bundle; master is the engine side, slave the key source / RAM side.
interface rc4_ksa_engine_if
  import rc4_pkg::*;
#(
  parameter int ADDR_W    = RC4_ADDR_W,
  parameter int DATA_W    = RC4_DATA_W,
  parameter int KEY_BYTES = RC4_KEY_BYTES
);
  logic                        sig_start;
  logic                        ksa_en;
  logic [KEY_BYTES*DATA_W-1:0] secret_key;
  logic [DATA_W-1:0]           mem_q;
  logic [ADDR_W-1:0]           mem_address;
  logic [DATA_W-1:0]           mem_data;
  logic                        wren;
  logic                        busy;
  logic                        t_done;

  modport master (
    input  sig_start, ksa_en, secret_key, mem_q,
    output mem_address, mem_data, wren, busy, t_done
  );

  modport slave (
    output sig_start, ksa_en, secret_key, mem_q,
    input  mem_address, mem_data, wren, busy, t_done
  );
endinterface

// File: rtl/rc4_ksa_engine_key_sel.sv
// Latches the key at run start and presents key word kidx, stepping with a wrapping index.
// Word 0 sits in the most-significant DATA_W bits of the latched key.
module rc4_key_sel
  import rc4_pkg::*;
#(
  parameter int DATA_W    = RC4_DATA_W,
  parameter int KEY_BYTES = RC4_KEY_BYTES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_i,
  input  logic                        advance_i,
  input  logic [KEY_BYTES*DATA_W-1:0] key_i,
  output logic [DATA_W-1:0]           key_word_o
);
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [KEY_BYTES*DATA_W-1:0] key_q, key_d;
  logic [KIDX_W-1:0]           kidx_q, kidx_d;

  always_comb begin
    key_d  = key_q;
    kidx_d = kidx_q;
    if (load_i) begin
      key_d  = key_i;
      kidx_d = '0;
    end else if (advance_i) begin
      kidx_d = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q  <= '0;
      kidx_q <= '0;
    end else begin
      key_q  <= key_d;
      kidx_q <= kidx_d;
    end
  end

  always_comb begin
    key_word_o = key_q[DATA_W-1:0];
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KIDX_W'(k)) key_word_o = key_q[(KEY_BYTES-1-k)*DATA_W +: DATA_W];
    end
  end
endmodule

// File: rtl/rc4_ksa_engine.sv
// Fills the S-box RAM with S[i]=i, then optionally runs the RC4 key-scheduling swap pass
// against a single-port RAM with one cycle of read latency.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int ADDR_W    = RC4_ADDR_W,
  parameter int DATA_W    = RC4_DATA_W,
  parameter int KEY_BYTES = RC4_KEY_BYTES
) (
  input logic              clk,
  input logic              reset,
  rc4_ksa_engine_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_I = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
  logic [DATA_W-1:0] si_q, si_d, sj_q, sj_d;
  logic              mode_q, mode_d;
  logic              key_load, key_adv;
  logic [DATA_W-1:0] key_word;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wr;

  rc4_key_sel #(.DATA_W(DATA_W), .KEY_BYTES(KEY_BYTES)) u_key_sel (
    .clk        (clk),
    .reset      (reset),
    .load_i     (key_load),
    .advance_i  (key_adv),
    .key_i      (bus.secret_key),
    .key_word_o (key_word)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    mode_d   = mode_q;
    key_load = 1'b0;
    key_adv  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.sig_start) begin
          key_load = 1'b1;
          mode_d   = bus.ksa_en;
          i_d      = '0;
          j_d      = '0;
          state_d  = INIT_WR;
        end
      end
      INIT_WR: begin
        i_d = i_q + 1'b1;
        if (i_q == LAST_I) state_d = mode_q ? RD_I : DONE;
      end
      RD_I:   state_d = WAIT_I;
      WAIT_I: state_d = CAP_I;
      CAP_I: begin
        si_d    = bus.mem_q;
        // Sum is DATA_W wide; only its low ADDR_W bits form the new j.
        j_d     = ADDR_W'(DATA_W'(j_q) + bus.mem_q + key_word);
        state_d = RD_J;
      end
      RD_J:   state_d = WAIT_J;
      WAIT_J: state_d = CAP_J;
      CAP_J: begin
        sj_d    = bus.mem_q;
        state_d = WR_I;
      end
      WR_I:   state_d = WR_J;
      WR_J: begin
        i_d     = i_q + 1'b1;
        key_adv = 1'b1;
        state_d = (i_q == LAST_I) ? DONE : RD_I;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      mode_q  <= mode_d;
    end
  end

  // Address is held through the wait/capture states so the RAM keeps returning the same word.
  always_comb begin
    addr = '0;
    data = '0;
    wr   = 1'b0;
    unique case (state_q)
      INIT_WR: begin
        addr = i_q;
        data = DATA_W'(i_q);
        wr   = 1'b1;
      end
      RD_I, WAIT_I, CAP_I: addr = i_q;
      RD_J, WAIT_J, CAP_J: addr = j_q;
      WR_I: begin
        addr = i_q;
        data = sj_q;
        wr   = 1'b1;
      end
      WR_J: begin
        addr = j_q;
        data = si_q;
        wr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_address = addr;
  assign bus.mem_data    = data;
  assign bus.wren        = wr;
  assign bus.busy        = state_is_busy(state_q);
  assign bus.t_done      = (state_q == DONE);
endmodule

// File: doc/rc4_ksa_engine.md
Name: rc4_ksa_engine

Overview:
Parametrised successor to the RC4 memory-init FSM. Fills the S-box RAM with S[i]=i, then optionally runs the RC4 key-scheduling pass (j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]) against a single-port synchronous RAM. It sits between the key source (switches or cracker loop) and the S-box RAM, and signals completion to the decrypt stage.

Parameters:
ADDR_W, 8, S-box address width; DEPTH = 2**ADDR_W.
DATA_W, 8, S-box word width; must satisfy DATA_W >= ADDR_W.
KEY_BYTES, 3, number of key words of DATA_W bits each.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
sig_start  in  1  level; accepted only in IDLE or DONE.
ksa_en  in  1  0 = init only, 1 = init + KSA; latched at start.
secret_key  in  KEY_BYTES*DATA_W  key; latched at start; word 0 = most-significant DATA_W bits.
mem_q  in  DATA_W  RAM read data, valid 1 cycle after address is presented.
mem_address  out  ADDR_W  RAM address.
mem_data  out  DATA_W  RAM write data.
wren  out  1  RAM write enable.
busy  out  1  high in every state except IDLE and DONE.
t_done  out  1  level; high in DONE until the next start is accepted or reset.

Behaviour:
- Reset: state=IDLE; i, j, key index, si, sj, latched key and mode all 0; mem_address=0, mem_data=0, wren=0, busy=0, t_done=0. Reset mid-run aborts immediately; RAM contents are left partial and are not defined.
- Acceptance cycle: call it cycle 0, with sig_start high in IDLE or DONE. Latch secret_key and ksa_en; clear i, j and key index; clear t_done; go to INIT_WR.
- sig_start while busy is ignored. sig_start still high in DONE restarts the run, so the caller deasserts it after one cycle.
- INIT_WR:
  - mem_address=i, mem_data=zero-extend(i), wren=1; i++.
  - After i=DEPTH-1: go to DONE if !ksa_en, else go to KSA_RD_I with i=0.
  - Init-only run: t_done rises at cycle DEPTH+1.
- KSA loop, 8 cycles per i:
  - RD_I: addr=i, wren=0.
  - WAIT_I.
  - CAP_I: si<=mem_q; j <= (j + mem_q + key[kidx]) mod DEPTH, keeping the low ADDR_W bits of the DATA_W-wide sum.
  - RD_J: addr=j.
  - WAIT_J.
  - CAP_J: sj<=mem_q.
  - WR_I: addr=i, data=sj, wren=1.
  - WR_J: addr=j, data=si, wren=1.
  - After WR_J: i++, kidx = (kidx==KEY_BYTES-1) ? 0 : kidx+1 (wrap counter, no divider).
  - After WR_J with i==DEPTH-1: go to DONE; otherwise go to RD_I.
- i==j: both writes hit the same address with si, leaving the value unchanged. This is correct and needs no special case.
- Full run: t_done rises at cycle 9*DEPTH+1 (2305 cycles for the defaults).
- wren is high only in INIT_WR, WR_I and WR_J. All outputs are registered or decoded from the registered state only; no combinational path from mem_q to any output.
- Key values are consumed modulo DEPTH; no overflow flag.

Decomposition:
- Package rc4_pkg holds the state enum (IDLE, INIT_WR, RD_I, WAIT_I, CAP_I, RD_J, WAIT_J, CAP_J, WR_I, WR_J, DONE) and the default constants ADDR_W, DATA_W and KEY_BYTES.
- Sub-module rc4_key_sel (natural choice): latches secret_key and returns key word kidx with its wrapping index counter.
- The FSM and datapath stay in the top module.

Test Plan:
- Default params, ksa_en=0, 1-cycle start pulse -> wren high for exactly 256 consecutive cycles with addr=data=0..255; t_done at cycle 257; busy low after; RAM S[i]=i.
- ADDR_W=2, KEY_BYTES=1, key=0x00, ksa_en=1 -> t_done at cycle 37; RAM = [0,2,3,1].
- Defaults, ksa_en=1, key=0x000249 -> final RAM matches a software RC4 KSA model word-for-word; t_done at cycle 2305.
- sig_start pulsed mid-KSA (cycle 600) -> ignored, completion cycle unchanged; sig_start in DONE -> t_done drops next cycle and init restarts at address 0.
- reset asserted at cycle 1000 -> next cycle all outputs 0, state IDLE; a fresh start then completes a normal run with correct results.
- i==j case (ADDR_W=2, key=0x00 at i=0 and i=1) -> two writes to the same address with unchanged data; result as in scenario 2.
